alu_arbiter: RTL and testbench

Sequencing and sharing controller for the single-cycle combinational `ALU`. It accepts operation requests from two requesters, for example the execute stage and a branch/compare unit. It arbitrates round-robin between them and drives the ALU's `ALUop`, `regin1`, `regin2` and `aluwe` inputs. It captures `regout` and returns the result to the winning requester over a valid/ready handshake.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter_rr_arb2.sv | 33 +++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: ALU function codes
// and the controller's state encoding.
package alu_pkg;

    localparam logic [5:0] OP_SLL  = 6'h00;
    localparam logic [5:0] OP_SRL  = 6'h02;
    localparam logic [5:0] OP_SRA  = 6'h03;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_ADDU = 6'h21;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_SUBU = 6'h23;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_XOR  = 6'h26;
    localparam logic [5:0] OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2a;
    localparam logic [5:0] OP_SEQ  = 6'h2b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two request/response channels plus the ALU-facing signals.
// The slave modport is the controller; the master modport is its environment.
interface alu_arbiter_if #(
    parameter int W   = 32,
    parameter int OPW = 6
);
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [W-1:0]   req0_a;
    logic [W-1:0]   req0_b;
    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [W-1:0]   req1_a;
    logic [W-1:0]   req1_b;
    logic           resp0_valid;
    logic           resp0_ready;
    logic           resp1_valid;
    logic           resp1_ready;
    logic [W-1:0]   resp_data;
    logic           busy;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_we;
    logic [W-1:0]   alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready, alu_result,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_data, busy, alu_op, alu_a, alu_b, alu_we
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready, alu_result,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_data, busy, alu_op, alu_a, alu_b, alu_we
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The last-grant pointer moves only when a
// grant is actually issued, so a withdrawn request does not cost a turn.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    // High when req1 won last, which makes req0 the favoured requester.
    logic last_reg;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = last_reg ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (|grant) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: grant, issue with a
// single alu_we toggle, capture the result one cycle later, then hold it
// until the winning requester takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    alu_arbiter_if.slave   bus
);

    state_t         state_reg;
    logic           id_reg;
    logic           busy_reg;
    logic [1:0]     resp_valid_reg;
    logic [W-1:0]   resp_data_reg;
    logic [OPW-1:0] alu_op_reg;
    logic [W-1:0]   alu_a_reg;
    logic [W-1:0]   alu_b_reg;
    logic           alu_we_reg;

    logic [1:0]     req_valid;
    logic [1:0]     resp_ready;
    logic [1:0]     resp_fire;
    logic [1:0]     grant;
    logic           idle;
    logic           accept;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign resp_ready = {bus.resp1_ready, bus.resp0_ready};

    // Grants are withheld during the reset cycle so nothing offered then is taken.
    assign idle   = (state_reg == ST_IDLE) && !rst;
    assign accept = |grant;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .enable (idle),
        .grant  (grant)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign resp_fire[gi] = resp_valid_reg[gi] & resp_ready[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            id_reg         <= 1'b0;
            busy_reg       <= 1'b0;
            resp_valid_reg <= 2'b00;
            resp_data_reg  <= '0;
            alu_op_reg     <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_we_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        alu_op_reg <= grant[1] ? bus.req1_op : bus.req0_op;
                        alu_a_reg  <= grant[1] ? bus.req1_a  : bus.req0_a;
                        alu_b_reg  <= grant[1] ? bus.req1_b  : bus.req0_b;
                        alu_we_reg <= ~alu_we_reg;
                        id_reg     <= grant[1];
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The ALU re-evaluated on the toggle issued at accept.
                    resp_data_reg          <= bus.alu_result;
                    resp_valid_reg[id_reg] <= 1'b1;
                    state_reg              <= ST_RESP;
                end
                ST_RESP: begin
                    if (|resp_fire) begin
                        resp_valid_reg <= 2'b00;
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.resp0_valid = resp_valid_reg[0];
    assign bus.resp1_valid = resp_valid_reg[1];
    assign bus.resp_data   = resp_data_reg;
    assign bus.busy        = busy_reg;
    assign bus.alu_op      = alu_op_reg;
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_we      = alu_we_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level reference model,
// directed scenarios followed by randomized traffic with backpressure.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int OPW = 6;

    typedef struct {
        logic [OPW-1:0] op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.W(W), .OPW(OPW)) bus ();

    alu_arbiter #(.W(W), .OPW(OPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [W-1:0] alu_f(logic [OPW-1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            OP_SLL:          return a << b;
            OP_SRL:          return a >> b;
            OP_SRA:          return $unsigned($signed(a) >>> b);
            OP_ADD, OP_ADDU: return a + b;
            OP_SUB, OP_SUBU: return a - b;
            OP_AND:          return a & b;
            OP_OR:           return a | b;
            OP_XOR:          return a ^ b;
            OP_NOR:          return ~(a | b);
            OP_SLT:          return ($signed(a) < $signed(b)) ? 1 : 0;
            OP_SEQ:          return (a == b) ? 1 : 0;
            default:         return '0;
        endcase
    endfunction

    // The ALU only re-evaluates on an edge of alu_we.
    int we_count = 0;
    always @(bus.alu_we) begin
        we_count++;
        #2 bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    req_t q0[$];
    req_t q1[$];
    req_t cur0, cur1;
    bit   drop_en = 1'b0;
    bit   rand_rr = 1'b0;

    // Reference model: one transaction in flight, responses due two cycles after accept.
    bit         m_busy = 1'b0;
    int         m_id   = 0;
    bit         m_last = 1'b1;
    logic       m_we   = 1'b0;
    int         m_acc  = 0;
    req_t       m_req;
    logic [W-1:0] m_res;

    int           done_id[$];
    logic [W-1:0] done_data[$];
    int           done_acc[$];
    int           done_hs[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OPW-1:0] pick_op();
        case ($urandom_range(14))
            0: return OP_SLL;   1: return OP_SRL;   2: return OP_SRA;
            3: return OP_ADD;   4: return OP_ADDU;  5: return OP_SUB;
            6: return OP_SUBU;  7: return OP_AND;   8: return OP_OR;
            9: return OP_XOR;   10: return OP_NOR;  11: return OP_SLT;
            12: return OP_SEQ;  13: return 6'h3f;
            default: return 6'h11;
        endcase
    endfunction

    task automatic tick();
        bit r0 = 1'b0;
        bit r1 = 1'b0;
        bit hs = 1'b0;
        bit in_resp;
        @(negedge clk);
        if (!rst) begin
            r0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
            r1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
            in_resp = m_busy && (cyc >= m_acc + 2);
            chk("req0_ready", bus.req0_ready, r0);
            chk("req1_ready", bus.req1_ready, r1);
            chk("busy", bus.busy, m_busy);
            chk("alu_we", bus.alu_we, m_we);
            chk("resp0_valid", bus.resp0_valid, in_resp && m_id == 0);
            chk("resp1_valid", bus.resp1_valid, in_resp && m_id == 1);
            if (m_busy) begin
                chk("alu_op", bus.alu_op, m_req.op);
                chk("alu_a", bus.alu_a, m_req.a);
                chk("alu_b", bus.alu_b, m_req.b);
            end
            if (in_resp) begin
                chk("resp_data", bus.resp_data, m_res);
                hs = (m_id == 0) ? bus.resp0_ready : bus.resp1_ready;
            end
            if (hs) begin
                done_id.push_back(m_id);
                done_data.push_back(bus.resp_data);
                done_acc.push_back(m_acc);
                done_hs.push_back(cyc);
                $display("txn id=%0d op=%02h a=%0h b=%0h data=%0h accept=%0d resp=%0d",
                         m_id, m_req.op, m_req.a, m_req.b, bus.resp_data, m_acc, cyc);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_we   = 1'b0;
        end else if (hs) begin
            m_busy = 1'b0;
        end else if (r0 || r1) begin
            m_busy = 1'b1;
            m_id   = r1 ? 1 : 0;
            m_last = r1;
            m_req  = r1 ? cur1 : cur0;
            m_res  = alu_f(m_req.op, m_req.a, m_req.b);
            m_acc  = cyc;
            m_we   = ~m_we;
        end
        cyc++;
        #1;
        if (r0) bus.req0_valid = 1'b0;
        if (r1) bus.req1_valid = 1'b0;
        if (drop_en && bus.req0_valid && $urandom_range(15) == 0) bus.req0_valid = 1'b0;
        if (drop_en && bus.req1_valid && $urandom_range(15) == 0) bus.req1_valid = 1'b0;
        if (!bus.req0_valid && q0.size() > 0) begin
            cur0 = q0.pop_front();
            bus.req0_valid = 1'b1;
            bus.req0_op = cur0.op; bus.req0_a = cur0.a; bus.req0_b = cur0.b;
        end
        if (!bus.req1_valid && q1.size() > 0) begin
            cur1 = q1.pop_front();
            bus.req1_valid = 1'b1;
            bus.req1_op = cur1.op; bus.req1_a = cur1.a; bus.req1_b = cur1.b;
        end
        if (rand_rr) begin
            bus.resp0_ready = ($urandom_range(2) != 0);
            bus.resp1_ready = ($urandom_range(2) != 0);
        end
    endtask

    task automatic wait_txns(int n, int budget);
        int start = done_id.size();
        for (int i = 0; i < budget && done_id.size() < start + n; i++) tick();
        chk("txn_count", done_id.size() - start, n);
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", bus.busy, 0);
        chk("rst_resp0_valid", bus.resp0_valid, 0);
        chk("rst_resp1_valid", bus.resp1_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_we", bus.alu_we, 0);
    endtask

    initial begin
        int k, w, s;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
        bus.alu_result = 0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_reset_vals();

        // Single ADD from req0.
        w = we_count;
        q0.push_back('{OP_ADD, 32'd5, 32'd7});
        wait_txns(1, 20);
        k = done_id.size() - 1;
        chk("add_data", done_data[k], 12);
        chk("add_id", done_id[k], 0);
        chk("add_latency", done_hs[k] - done_acc[k], 2);
        chk("add_we_toggles", we_count - w, 1);

        // Both valid straight out of reset.
        q0.push_back('{OP_SUB, 32'd10, 32'd3});
        q1.push_back('{OP_SLT, 32'd3, 32'd9});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals();
        s = done_id.size();
        wait_txns(2, 30);
        chk("both_first_id", done_id[s], 0);
        chk("both_first_data", done_data[s], 7);
        chk("both_second_id", done_id[s+1], 1);
        chk("both_second_data", done_data[s+1], 1);
        chk("both_accept_gap", done_acc[s+1] - done_acc[s], 3);

        // Response backpressure with the other requester waiting.
        bus.resp0_ready = 0;
        q0.push_back('{OP_ADD, 32'h1234, 32'd1});
        q1.push_back('{OP_AND, 32'hff, 32'h0f});
        for (int i = 0; i < 10 && !(m_busy && cyc >= m_acc + 2); i++) tick();
        repeat (4) tick();
        chk("bp_resp0_valid", bus.resp0_valid, 1);
        chk("bp_req1_ready", bus.req1_ready, 0);
        bus.resp0_ready = 1;
        s = done_id.size();
        wait_txns(2, 20);
        chk("bp_first_data", done_data[s], 32'h1235);
        chk("bp_second_id", done_id[s+1], 1);
        chk("bp_next_accept", done_acc[s+1] - done_hs[s], 1);

        // Reset during WAIT drops the operation; a request offered in the reset cycle is ignored.
        q0.push_back('{OP_ADD, 32'd1, 32'd1});
        for (int i = 0; i < 10 && !(m_busy && cyc == m_acc + 1); i++) tick();
        chk("rst_wait_reached", m_busy && cyc == m_acc + 1, 1);
        q0.push_back('{OP_XOR, 32'd6, 32'd3});
        cur1 = '{OP_SUB, 32'd9, 32'd2};
        bus.req1_op = cur1.op; bus.req1_a = cur1.a; bus.req1_b = cur1.b;
        bus.req1_valid = 1'b1;
        rst = 1'b1;
        s = done_id.size();
        tick();
        rst = 1'b0;
        check_reset_vals();
        wait_txns(2, 30);
        chk("rst_first_id", done_id[s], 0);
        chk("rst_first_data", done_data[s], 5);
        chk("rst_second_data", done_data[s+1], 7);

        // Undefined opcode returns whatever the ALU yields.
        q0.push_back('{6'h3f, 32'd1, 32'd1});
        wait_txns(1, 20);
        k = done_id.size() - 1;
        chk("undef_data", done_data[k], 0);
        chk("undef_latency", done_hs[k] - done_acc[k], 2);

        // Three back-to-back operations from req1 alone.
        w = we_count;
        s = done_id.size();
        q1.push_back('{OP_OR, 32'hf0, 32'h0f});
        q1.push_back('{OP_SLL, 32'd1, 32'd4});
        q1.push_back('{OP_XOR, 32'hff, 32'h0f});
        wait_txns(3, 40);
        chk("b2b_or", done_data[s], 32'hff);
        chk("b2b_sll", done_data[s+1], 16);
        chk("b2b_xor", done_data[s+2], 32'hf0);
        chk("b2b_gap1", done_acc[s+1] - done_acc[s], 3);
        chk("b2b_gap2", done_acc[s+2] - done_acc[s+1], 3);
        chk("b2b_we_toggles", we_count - w, 3);
        chk("b2b_id", done_id[s+2], 1);

        // Randomized traffic with drops and backpressure.
        drop_en = 1'b1;
        rand_rr = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 3 && $urandom_range(2) == 0)
                q0.push_back('{pick_op(), $urandom, ($urandom_range(1) != 0) ? $urandom_range(40) : $urandom});
            if (q1.size() < 3 && $urandom_range(2) == 0)
                q1.push_back('{pick_op(), $urandom, ($urandom_range(1) != 0) ? $urandom_range(40) : $urandom});
            tick();
        end
        drop_en = 1'b0;
        rand_rr = 1'b0;
        bus.resp0_ready = 1;
        bus.resp1_ready = 1;
        for (int i = 0; i < 200 && (m_busy || bus.req0_valid || bus.req1_valid ||
                                    q0.size() > 0 || q1.size() > 0); i++) tick();
        tick();
        chk("drain_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
